// File: rtl/sr_excitation_driver_pkg.sv
// sr_excitation_driver_pkg: FSM state encoding, excitation constants ({s,r}) and the excitation-table helper
package sr_excitation_driver_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_APPLY, ST_SETTLE, ST_CHECK} state_t;
  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_SET  = 2'b10;
  localparam logic [1:0] SR_RST  = 2'b01;
  function automatic logic [1:0] excite(input logic known, input logic cur_q, input logic tgt_q);
    return (!known || cur_q != tgt_q) ? (tgt_q ? SR_SET : SR_RST) : SR_HOLD;
  endfunction
endpackage

// File: rtl/sr_excitation_driver_if.sv
// sr_excitation_driver_if: target stream (tgt_valid/tgt_ready/tgt_bit), s/r drive, q_fb feedback, busy and error status; master=command side, slave=driver
interface sr_excitation_driver_if #(parameter int ERR_W = 8);
  logic tgt_valid, tgt_ready, tgt_bit, s, r, q_fb, busy, err_clr, err_flag;
  logic [ERR_W-1:0] err_cnt;
  modport master (output tgt_valid, tgt_bit, q_fb, err_clr, input tgt_ready, s, r, busy, err_cnt, err_flag);
  modport slave (input tgt_valid, tgt_bit, q_fb, err_clr, output tgt_ready, s, r, busy, err_cnt, err_flag);
endinterface

// File: rtl/sr_excitation_driver_cmd_fifo.sv
// sr_excitation_driver_cmd_fifo: 1-bit DEPTH-entry FIFO (clk, rst, i_push, i_pop, i_data -> o_data head, o_full, o_empty registered; wrap by pointer MSB)
module sr_excitation_driver_cmd_fifo #(parameter int DEPTH = 4) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_pop,
  input  logic i_data,
  output logic o_data,
  output logic o_full,
  output logic o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0] r_mem;
  logic [AW:0] r_wptr, r_rptr, w_wnext, w_rnext;
  logic w_push, w_pop;
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  assign w_wnext = r_wptr + (AW+1)'(w_push);
  assign w_rnext = r_rptr + (AW+1)'(w_pop);
  assign o_data = r_mem[r_rptr[AW-1:0]];
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      o_full <= 1'b0;
      o_empty <= 1'b1;
    end else begin
      r_wptr <= w_wnext;
      r_rptr <= w_rnext;
      o_full <= (w_wnext[AW] != w_rnext[AW]) && (w_wnext[AW-1:0] == w_rnext[AW-1:0]);
      o_empty <= w_wnext == w_rnext;
    end
endmodule

// File: rtl/sr_excitation_driver.sv
// sr_excitation_driver: target-bit stream -> SR excitation pulses with q_fb check (clk, rst, bus: tgt_*, s, r, q_fb, busy, err_clr, err_cnt, err_flag)
module sr_excitation_driver import sr_excitation_driver_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input logic clk,
  input logic rst,
  sr_excitation_driver_if.slave bus
);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  state_t r_state;
  logic r_tgt_q, r_cur_q, r_known;
  logic w_full, w_empty, w_head, w_pop, w_chk, w_mis;
  logic [1:0] w_sr;
  sr_excitation_driver_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .i_push(bus.tgt_valid), .i_pop(w_pop), .i_data(bus.tgt_bit),
    .o_data(w_head), .o_full(w_full), .o_empty(w_empty)
  );
  assign w_pop = r_state == ST_APPLY;
  assign w_chk = r_state == ST_CHECK;
  assign w_sr = excite(r_known, r_cur_q, w_head);
  assign w_mis = bus.q_fb != r_tgt_q;
  assign bus.tgt_ready = !w_full;
  assign bus.busy = r_state != ST_IDLE || !w_empty;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= ST_IDLE;
      r_tgt_q <= 1'b0;
      r_cur_q <= 1'b0;
      r_known <= 1'b0;
      bus.s <= 1'b0;
      bus.r <= 1'b0;
      bus.err_cnt <= '0;
      bus.err_flag <= 1'b0;
    end else begin
      r_state <= (r_state == ST_APPLY) ? ST_SETTLE : (r_state == ST_SETTLE) ? ST_CHECK : w_empty ? ST_IDLE : ST_APPLY;
      bus.s <= w_pop && w_sr[1];
      bus.r <= w_pop && w_sr[0];
      if (w_pop) r_tgt_q <= w_head;
      if (w_chk) begin
        r_cur_q <= r_tgt_q;
        r_known <= 1'b1;
      end
      if (bus.err_clr) begin
        bus.err_cnt <= '0;
        bus.err_flag <= 1'b0;
      end else if (w_chk && w_mis) begin
        bus.err_cnt <= (bus.err_cnt == ERR_MAX) ? bus.err_cnt : bus.err_cnt + 1'b1;
        bus.err_flag <= 1'b1;
      end
    end
endmodule

// File: tb/tb_sr_excitation_driver.sv
// tb_sr_excitation_driver: scenario tasks plus a timeline reference model checked every cycle
module tb_sr_excitation_driver;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  sr_excitation_driver_if #(.ERR_W(8)) bus ();
  sr_excitation_driver_if #(.ERR_W(2)) bus2 ();
  sr_excitation_driver #(.DEPTH(DEPTH), .ERR_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  sr_excitation_driver #(.DEPTH(DEPTH), .ERR_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  int checks = 0, failures = 0;
  logic ff_q = 1'b0, stuck = 1'b0, stuck_val = 1'b0, mon_en = 1'b0;
  always @(posedge clk) if (bus.s) ff_q <= 1'b1; else if (bus.r) ff_q <= 1'b0;
  assign bus.q_fb = stuck ? stuck_val : ff_q;
  assign bus2.q_fb = 1'b0;
  // Reference model: each accepted bit is applied at edge max(push+2, previous apply+3) and checked two edges later.
  int cyc = 0, last_ap, chk_at, m_err;
  int ap_q[$];
  logic bit_q[$];
  logic chk_bit, m_cur, m_known, m_s, m_r, m_flag, m_ready, m_busy;
  always @(posedge clk or posedge rst) begin : model
    logic b, mis, rdy;
    if (rst) begin
      ap_q.delete(); bit_q.delete();
      last_ap = -100; chk_at = -100; m_err = 0; m_flag = 0; m_cur = 0; m_known = 0;
      m_s = 0; m_r = 0; m_ready = 1; m_busy = 0;
    end else begin
      cyc++;
      rdy = ap_q.size() < DEPTH;
      mis = (cyc == chk_at) && (bus.q_fb !== chk_bit);
      if (cyc == chk_at) begin m_cur = chk_bit; m_known = 1; end
      if (bus.err_clr) begin m_err = 0; m_flag = 0; end
      else if (mis) begin m_err = (m_err < 255) ? m_err + 1 : 255; m_flag = 1; end
      m_s = 0; m_r = 0;
      if (ap_q.size() > 0 && ap_q[0] == cyc) begin
        void'(ap_q.pop_front());
        b = bit_q.pop_front();
        if (!m_known || m_cur != b) begin m_s = b; m_r = !b; end
        chk_at = cyc + 2; chk_bit = b;
      end
      if (bus.tgt_valid && rdy) begin
        last_ap = (cyc + 2 > last_ap + 3) ? cyc + 2 : last_ap + 3;
        ap_q.push_back(last_ap); bit_q.push_back(bus.tgt_bit);
      end
      m_ready = ap_q.size() < DEPTH;
      m_busy = ap_q.size() > 0 || cyc < last_ap + 2;
    end
  end
  always @(negedge clk) if (mon_en) begin
    checks++;
    if ({bus.s, bus.r, bus.tgt_ready, bus.busy, bus.err_flag} !== {m_s, m_r, m_ready, m_busy, m_flag} || bus.err_cnt !== 8'(m_err)) begin
      failures++;
      $display("FAIL monitor t=%0t s,r,ready,busy,flag got=%b exp=%b err_cnt got=%0d exp=%0d", $time,
        {bus.s, bus.r, bus.tgt_ready, bus.busy, bus.err_flag}, {m_s, m_r, m_ready, m_busy, m_flag}, bus.err_cnt, m_err);
    end
    checks++;
    if (bus.s & bus.r) begin failures++; $display("FAIL s_and_r t=%0t got s=1 r=1 exp not both", $time); end
  end
  task automatic send(input logic b);
    int n = 0;
    @(negedge clk);
    bus.tgt_valid = 1'b1; bus.tgt_bit = b;
    @(posedge clk);
    while (!bus.tgt_ready && n < 50) begin n++; @(posedge clk); end
    checks++;
    if (n >= 50) begin failures++; $display("FAIL send_accept got=no accept exp=accept within 50 cycles"); end
  endtask
  task automatic stop_in();
    @(negedge clk);
    bus.tgt_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 300) begin n++; @(negedge clk); end
    checks++;
    if (n >= 300) begin failures++; $display("FAIL wait_idle got=busy exp=idle within 300 cycles"); end
  endtask
  task automatic test_reset();
    bus.tgt_valid = 0; bus.tgt_bit = 0; bus.err_clr = 0;
    bus2.tgt_valid = 0; bus2.tgt_bit = 0; bus2.err_clr = 0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.s, bus.r, bus.tgt_ready, bus.busy, bus.err_flag} !== 5'b00100 || bus.err_cnt !== 8'd0) begin
      failures++; $display("FAIL reset_state got=%b cnt=%0d exp=00100 cnt=0", {bus.s, bus.r, bus.tgt_ready, bus.busy, bus.err_flag}, bus.err_cnt);
    end
    checks++;
    if ({bus2.s, bus2.r, bus2.tgt_ready, bus2.busy, bus2.err_flag} !== 5'b00100 || bus2.err_cnt !== 2'd0) begin
      failures++; $display("FAIL reset_state2 got=%b cnt=%0d exp=00100 cnt=0", {bus2.s, bus2.r, bus2.tgt_ready, bus2.busy, bus2.err_flag}, bus2.err_cnt);
    end
    rst = 1'b0;
    mon_en = 1'b1;
  endtask
  task automatic test_first_forced();
    send(1'b1); stop_in();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.s, bus.r} !== 2'b10) begin failures++; $display("FAIL first_forced got s,r=%b exp=10", {bus.s, bus.r}); end
    @(negedge clk);
    checks++;
    if ({bus.s, bus.r} !== 2'b00) begin failures++; $display("FAIL pulse_width got s,r=%b exp=00", {bus.s, bus.r}); end
    wait_idle();
    checks++;
    if (ff_q !== 1'b1 || bus.err_cnt !== 8'd0) begin failures++; $display("FAIL first_q got q=%b cnt=%0d exp q=1 cnt=0", ff_q, bus.err_cnt); end
  endtask
  task automatic test_back_to_back();
    int ns = 0, nr = 0, s_at = -1, r_at = -1;
    send(1'b1); send(1'b0); send(1'b0); send(1'b1); stop_in();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.s) begin ns++; s_at = i; end
      if (bus.r) begin nr++; r_at = i; end
    end
    checks++;
    if (ns != 1 || nr != 1) begin failures++; $display("FAIL b2b_pulses got s=%0d r=%0d exp s=1 r=1", ns, nr); end
    checks++;
    if (s_at - r_at != 6) begin failures++; $display("FAIL b2b_spacing got=%0d exp=6", s_at - r_at); end
    checks++;
    if (ff_q !== 1'b1 || bus.err_cnt !== 8'd0) begin failures++; $display("FAIL b2b_q got q=%b cnt=%0d exp q=1 cnt=0", ff_q, bus.err_cnt); end
    wait_idle();
  endtask
  task automatic test_full();
    int acc = 0, t = 0;
    @(negedge clk);
    bus.tgt_valid = 1'b1; bus.tgt_bit = 1'($urandom_range(0, 1));
    while (t < 20) begin
      @(posedge clk);
      if (bus.tgt_ready) acc++;
      @(negedge clk);
      bus.tgt_bit = 1'($urandom_range(0, 1));
      t++;
      if (!bus.tgt_ready) break;
    end
    checks++;
    // one pop lands inside the fill window, so the FIFO admits DEPTH+1 bits before filling
    if (acc != DEPTH + 1 || bus.tgt_ready !== 1'b0) begin failures++; $display("FAIL fill got accepts=%0d ready=%b exp accepts=%0d ready=0", acc, bus.tgt_ready, DEPTH + 1); end
    @(negedge clk);
    checks++;
    if (bus.tgt_ready !== 1'b1) begin failures++; $display("FAIL ready_after_pop got=%b exp=1", bus.tgt_ready); end
    repeat (30) begin @(negedge clk); bus.tgt_bit = 1'($urandom_range(0, 1)); end
    bus.tgt_valid = 1'b0;
    wait_idle();
  endtask
  task automatic test_errors();
    stuck = 1'b1; stuck_val = 1'b0;
    send(1'b1); send(1'b1); send(1'b1); stop_in(); wait_idle();
    checks++;
    if (bus.err_cnt !== 8'd3 || bus.err_flag !== 1'b1) begin failures++; $display("FAIL err_count got cnt=%0d flag=%b exp cnt=3 flag=1", bus.err_cnt, bus.err_flag); end
    @(negedge clk); bus.err_clr = 1'b1;
    @(negedge clk); bus.err_clr = 1'b0;
    checks++;
    if (bus.err_cnt !== 8'd0 || bus.err_flag !== 1'b0) begin failures++; $display("FAIL err_clr got cnt=%0d flag=%b exp cnt=0 flag=0", bus.err_cnt, bus.err_flag); end
    send(1'b1); stop_in();
    repeat (3) @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk); bus.err_clr = 1'b0;
    checks++;
    if (bus.err_cnt !== 8'd0 || bus.err_flag !== 1'b0) begin failures++; $display("FAIL clr_wins got cnt=%0d flag=%b exp cnt=0 flag=0", bus.err_cnt, bus.err_flag); end
    wait_idle();
    stuck = 1'b0;
  endtask
  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      bus.tgt_valid = $urandom_range(0, 2) != 0;
      bus.tgt_bit = 1'($urandom_range(0, 1));
      bus.err_clr = $urandom_range(0, 19) == 0;
      if ($urandom_range(0, 29) == 0) begin stuck = 1'($urandom_range(0, 1)); stuck_val = 1'($urandom_range(0, 1)); end
    end
    @(negedge clk);
    bus.tgt_valid = 1'b0; bus.err_clr = 1'b0; stuck = 1'b0;
    wait_idle();
    checks++;
    if (bus.err_cnt !== 8'(m_err)) begin failures++; $display("FAIL random_err got=%0d exp=%0d", bus.err_cnt, m_err); end
  endtask
  task automatic test_saturation();
    int acc = 0, t = 0;
    @(negedge clk);
    bus2.tgt_valid = 1'b1; bus2.tgt_bit = 1'b1;
    while (acc < 5 && t < 100) begin @(posedge clk); if (bus2.tgt_ready) acc++; t++; end
    @(negedge clk);
    bus2.tgt_valid = 1'b0;
    t = 0;
    while (bus2.busy && t < 100) begin @(negedge clk); t++; end
    checks++;
    if (acc != 5 || bus2.busy !== 1'b0) begin failures++; $display("FAIL sat_stream got accepts=%0d busy=%b exp accepts=5 busy=0", acc, bus2.busy); end
    checks++;
    if (bus2.err_cnt !== 2'd3 || bus2.err_flag !== 1'b1) begin failures++; $display("FAIL saturate got cnt=%0d flag=%b exp cnt=3 flag=1", bus2.err_cnt, bus2.err_flag); end
  endtask
  task automatic test_reset_mid();
    send(1'b0); stop_in(); wait_idle();
    send(1'b1); stop_in();
    @(negedge clk); @(posedge clk); #2;
    checks++;
    if ({bus.s, bus.r} !== 2'b10) begin failures++; $display("FAIL pre_reset_s got s,r=%b exp=10", {bus.s, bus.r}); end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.s, bus.r, bus.busy, bus.tgt_ready} !== 4'b0001 || bus.err_cnt !== 8'd0) begin
      failures++; $display("FAIL async_reset got s,r,busy,ready=%b cnt=%0d exp=0001 cnt=0", {bus.s, bus.r, bus.busy, bus.tgt_ready}, bus.err_cnt);
    end
    @(negedge clk); rst = 1'b0;
    send(1'b0); stop_in();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.s, bus.r} !== 2'b01) begin failures++; $display("FAIL forced_after_reset got s,r=%b exp=01", {bus.s, bus.r}); end
    wait_idle();
  endtask
  initial begin
    test_reset();
    test_first_forced();
    test_back_to_back();
    test_full();
    test_errors();
    test_random();
    test_saturation();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout got=still running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
